// File: rtl/jtsdram_bank_ctrl_if.sv
`default_nettype none
// ============================================================================
// jtsdram_bank_ctrl_if : rd/wr/ack/rdy request bus between bank clients and
//                        the single-bank SDRAM controller
// Revision 1.0
// ============================================================================
interface jtsdram_bank_ctrl_if;
  logic        rd;
  logic        wr;
  logic [21:0] addr;
  logic [15:0] din;
  logic        ack;
  logic        rdy;
  logic [31:0] dout;

  modport master (output rd, wr, addr, din, input ack, rdy, dout);
  modport slave  (input rd, wr, addr, din, output ack, rdy, dout);
endinterface
`default_nettype wire

// File: rtl/jtsdram_bank_ctrl.sv
`default_nettype none
// ============================================================================
// jtsdram_bank_ctrl : single-bank SDRAM controller, closed page with
//                     auto-precharge, BL2 reads returning 32-bit words
// Revision 1.0
// ============================================================================
module jtsdram_bank_ctrl #(
  parameter logic [1:0] BA        = 2'd0,
  parameter int         CL        = 2,
  parameter int         TRCD      = 2,
  parameter int         TRP       = 2,
  parameter int         TRFC      = 7,
  parameter int         TREFI     = 390,
  parameter int         INIT_WAIT = 10000
) (
  input  wire                 clk,
  input  wire                 rst,
  jtsdram_bank_ctrl_if.slave  bus,
  output logic                init_done,
  output logic [3:0]          sdram_cmd,
  output logic [1:0]          sdram_ba,
  output logic [12:0]         sdram_a,
  output logic [1:0]          sdram_dqm,
  output logic [15:0]         sdram_dq_out,
  output logic                sdram_dq_oe,
  input  wire  [15:0]         sdram_dq_in
);

  localparam int CNT_W = $clog2(INIT_WAIT + TRFC + TRP + TRCD + CL + 8);
  localparam int RF_W  = $clog2(TREFI + 1);

  localparam logic [3:0] c_nop = 4'b0111;
  localparam logic [3:0] c_act = 4'b0011;
  localparam logic [3:0] c_rd  = 4'b0101;
  localparam logic [3:0] c_wr  = 4'b0100;
  localparam logic [3:0] c_pre = 4'b0010;
  localparam logic [3:0] c_ref = 4'b0001;
  localparam logic [3:0] c_mrs = 4'b0000;
  // Write burst single, sequential BL2
  localparam logic [12:0] c_mode = {3'b000, 1'b1, 2'b00, 3'(CL), 1'b0, 3'b001};

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_REF, S_INIT_MRS,
    S_IDLE, S_REFRESH, S_ACT, S_WR, S_RD, S_PRECHG
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RF_W-1:0]   refc_q, refc_d;
  logic              rfsh_pend_q, rfsh_pend_d;
  logic              ref2_q, ref2_d;
  logic              rnw_q, rnw_d;
  logic [21:0]       addr_q, addr_d;
  logic [15:0]       din_q, din_d;
  logic [15:0]       beat0_q, beat0_d;
  logic              ack_q, ack_d;
  logic              rdy_q, rdy_d;
  logic [31:0]       dout_q, dout_d;
  logic              init_done_q, init_done_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [12:0]       a_q, a_d;
  logic [1:0]        dqm_q, dqm_d;
  logic [15:0]       dq_out_q, dq_out_d;
  logic              oe_q, oe_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_INIT_WAIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    refc_d      = refc_q;
    rfsh_pend_d = rfsh_pend_q;
    ref2_d      = ref2_q;
    rnw_d       = rnw_q;
    addr_d      = addr_q;
    din_d       = din_q;
    beat0_d     = beat0_q;
    ack_d       = 1'b0;
    rdy_d       = 1'b0;
    dout_d      = dout_q;
    init_done_d = init_done_q;
    cmd_d       = c_nop;
    a_d         = a_q;
    dqm_d       = 2'b11;
    dq_out_d    = dq_out_q;
    oe_d        = 1'b0;

    if (init_done_q)
      refc_d = (refc_q == RF_W'(TREFI - 1)) ? '0 : refc_q + 1'b1;

    case (state_q)
      S_INIT_WAIT: if (cnt_q == CNT_W'(INIT_WAIT - 1)) begin
        cmd_d   = c_pre;
        a_d     = 13'h0400;
        cnt_d   = '0;
        state_d = S_INIT_PRE;
      end
      S_INIT_PRE: if (cnt_q == CNT_W'(TRP - 1)) begin
        cmd_d   = c_ref;
        ref2_d  = 1'b0;
        cnt_d   = '0;
        state_d = S_INIT_REF;
      end
      S_INIT_REF: if (cnt_q == CNT_W'(TRFC - 1)) begin
        cnt_d = '0;
        if (!ref2_q) begin
          cmd_d  = c_ref;
          ref2_d = 1'b1;
        end else begin
          cmd_d   = c_mrs;
          a_d     = c_mode;
          state_d = S_INIT_MRS;
        end
      end
      S_INIT_MRS: if (cnt_q == CNT_W'(1)) begin
        init_done_d = 1'b1;
        cnt_d       = '0;
        state_d     = S_IDLE;
      end
      S_IDLE: begin
        cnt_d = '0;
        if (rfsh_pend_q) begin
          cmd_d       = c_ref;
          rfsh_pend_d = 1'b0;
          state_d     = S_REFRESH;
        end else if (bus.rd || bus.wr) begin
          rnw_d   = bus.rd;
          addr_d  = bus.addr;
          din_d   = bus.din;
          cmd_d   = c_act;
          a_d     = bus.addr[21:9];
          ack_d   = 1'b1;
          state_d = S_ACT;
        end
      end
      // Leave one cycle early so the next command lands exactly TRFC after REF
      S_REFRESH: if (cnt_q == CNT_W'(TRFC - 2)) state_d = S_IDLE;
      S_ACT: if (cnt_q == CNT_W'(TRCD - 1)) begin
        a_d   = {2'b00, 1'b1, 1'b0, addr_q[8:0]};
        dqm_d = 2'b00;
        cnt_d = '0;
        if (rnw_q) begin
          cmd_d   = c_rd;
          state_d = S_RD;
        end else begin
          cmd_d    = c_wr;
          dq_out_d = din_q;
          oe_d     = 1'b1;
          state_d  = S_WR;
        end
      end
      S_WR: if (cnt_q == CNT_W'(1)) begin
        rdy_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_PRECHG;
      end
      // Pad input register adds one cycle on top of CL
      S_RD: begin
        if (cnt_q <= CNT_W'(CL + 1)) dqm_d = 2'b00;
        if (cnt_q == CNT_W'(CL + 1)) beat0_d = sdram_dq_in;
        if (cnt_q == CNT_W'(CL + 2)) begin
          dout_d  = {sdram_dq_in, beat0_q};
          rdy_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_PRECHG;
        end
      end
      S_PRECHG: if (cnt_q == CNT_W'(TRP)) begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_INIT_WAIT;
      end
    endcase

    if (init_done_q && refc_q == RF_W'(TREFI - 1)) rfsh_pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      refc_q      <= '0;
      rfsh_pend_q <= 1'b0;
      ref2_q      <= 1'b0;
      rnw_q       <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      beat0_q     <= '0;
      ack_q       <= 1'b0;
      rdy_q       <= 1'b0;
      dout_q      <= '0;
      init_done_q <= 1'b0;
      cmd_q       <= c_nop;
      a_q         <= '0;
      dqm_q       <= 2'b11;
      dq_out_q    <= '0;
      oe_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      refc_q      <= refc_d;
      rfsh_pend_q <= rfsh_pend_d;
      ref2_q      <= ref2_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      beat0_q     <= beat0_d;
      ack_q       <= ack_d;
      rdy_q       <= rdy_d;
      dout_q      <= dout_d;
      init_done_q <= init_done_d;
      cmd_q       <= cmd_d;
      a_q         <= a_d;
      dqm_q       <= dqm_d;
      dq_out_q    <= dq_out_d;
      oe_q        <= oe_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.rdy      = rdy_q;
  assign bus.dout     = dout_q;
  assign init_done    = init_done_q;
  assign sdram_cmd    = cmd_q;
  assign sdram_ba     = BA;
  assign sdram_a      = a_q;
  assign sdram_dqm    = dqm_q;
  assign sdram_dq_out = dq_out_q;
  assign sdram_dq_oe  = oe_q;

endmodule
`default_nettype wire

// File: tb/tb_jtsdram_bank_ctrl.sv
`default_nettype none
// ============================================================================
// tb_jtsdram_bank_ctrl : scoreboard bench with an SDRAM pin model
// Revision 1.0
// ============================================================================
module tb_jtsdram_bank_ctrl;

  localparam int INIT_WAIT = 20;
  localparam int TREFI     = 300;
  localparam int CL        = 2;
  localparam int TRCD      = 2;
  localparam int TRP       = 2;
  localparam int TRFC      = 7;

  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RDC = 4'b0101, WRC = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_done;
  logic [3:0]  cmd;
  logic [1:0]  ba;
  logic [12:0] a;
  logic [1:0]  dqm;
  logic [15:0] dq_out;
  logic        oe;
  logic [15:0] dq_in;

  jtsdram_bank_ctrl_if bus();

  jtsdram_bank_ctrl #(.INIT_WAIT(INIT_WAIT), .TREFI(TREFI)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .init_done    (init_done),
    .sdram_cmd    (cmd),
    .sdram_ba     (ba),
    .sdram_a      (a),
    .sdram_dqm    (dqm),
    .sdram_dq_out (dq_out),
    .sdram_dq_oe  (oe),
    .sdram_dq_in  (dq_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          rnw;
    logic [21:0] addr;
    logic [15:0] din;
    logic [31:0] dout;
  } req_t;

  req_t req_q[$];
  req_t cur;
  bit   have_cur = 0;
  bit   after_wr = 0;
  int   t_ack = 0;
  int   last_ref = -1;
  int   n_ref = 0;
  int   checks = 0;
  int   failures = 0;

  logic [15:0] mem [logic [21:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rdmem(input logic [21:0] k);
    return mem.exists(k) ? mem[k] : 16'h0000;
  endfunction

  // SDRAM model: data lands on the pads CL+1 and CL+2 cycles after READ
  logic [12:0] m_row = '0;
  logic [21:0] m_key = '0;
  int          m_age = 0;
  bit          m_act = 0;
  always @(negedge clk) begin
    dq_in = 16'hDEAD;
    if (m_act) begin
      m_age++;
      if (m_age == CL + 1) dq_in = rdmem(m_key);
      else if (m_age == CL + 2) begin
        dq_in = rdmem({m_key[21:9], m_key[8:0] + 9'd1});
        m_act = 0;
      end
    end
    if (cmd == ACT) m_row = a;
    if (cmd == WRC) mem[{m_row, a[8:0]}] = dq_out;
    if (cmd == RDC) begin
      m_act = 1;
      m_age = 0;
      m_key = {m_row, a[8:0]};
    end
  end

  // Monitor: pops expectations on ack and checks them through rdy
  always @(negedge clk) if (!rst) begin
    if (after_wr) begin
      chk("wr_release_oe_dqm", {oe, dqm}, {1'b0, 2'b11});
      after_wr = 0;
    end
    if (bus.ack) begin
      chk("ack_has_request", req_q.size() > 0, 1);
      if (req_q.size() > 0) begin
        cur      = req_q.pop_front();
        have_cur = 1;
        t_ack    = cyc;
        chk("act_cmd_row", {cmd, 3'b000, a}, {ACT, 3'b000, cur.addr[21:9]});
      end
    end
    if (cmd == RDC || cmd == WRC) begin
      chk("access_in_txn", have_cur, 1);
      if (have_cur) begin
        chk("access_cmd", cmd, cur.rnw ? RDC : WRC);
        chk("access_a", a, {2'b00, 1'b1, 1'b0, cur.addr[8:0]});
        chk("access_trcd", cyc - t_ack, TRCD);
        if (!cur.rnw) begin
          chk("wr_pins", {oe, dqm, dq_out}, {1'b1, 2'b00, cur.din});
          after_wr = 1;
        end else begin
          chk("rd_dqm", dqm, 2'b00);
        end
      end
    end
    if (bus.rdy) begin
      chk("rdy_in_txn", have_cur, 1);
      if (have_cur) begin
        chk("ack_rdy_overlap", bus.ack, 0);
        if (cur.rnw) begin
          chk("rd_latency", cyc - t_ack, 7);
          chk("rd_dout", bus.dout, cur.dout);
        end else begin
          chk("wr_latency", cyc - t_ack, 4);
        end
        have_cur = 0;
      end
    end
    if (cmd == REF && init_done) begin
      last_ref = cyc;
      n_ref++;
    end
  end

  task automatic wait_out(input bit want_rdy, input string name, output int at);
    at = -1;
    for (int i = 0; i < 64 && at < 0; i++) begin
      @(negedge clk);
      if (want_rdy ? bus.rdy : bus.ack) at = cyc;
    end
    chk(name, at >= 0, 1);
  endtask

  task automatic push_req(input bit rnw, input logic [21:0] ad, input logic [15:0] d,
                          input logic [31:0] exp);
    req_t r;
    r.rnw = rnw; r.addr = ad; r.din = d; r.dout = exp;
    req_q.push_back(r);
  endtask

  task automatic do_req(input bit rnw, input logic [21:0] ad, input logic [15:0] d,
                        input logic [31:0] exp);
    int ta, tr;
    push_req(rnw, ad, d, exp);
    bus.addr = ad;
    bus.din  = d;
    if (rnw) bus.rd = 1'b1; else bus.wr = 1'b1;
    wait_out(0, "ack_seen", ta);
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    wait_out(1, "rdy_seen", tr);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_init(input int rel, output int t_done);
    int          tc[4];
    logic [3:0]  cc[4];
    logic [12:0] ac[4];
    int          n = 0;
    for (int i = 0; i < 4; i++) begin tc[i] = 0; cc[i] = NOP; ac[i] = '0; end
    t_done = -1;
    for (int i = 0; i < 200 && t_done < 0; i++) begin
      @(negedge clk);
      if (init_done) t_done = cyc;
      else if (cmd != NOP) begin
        if (n < 4) begin tc[n] = cyc; cc[n] = cmd; ac[n] = a; end
        n++;
      end
    end
    chk("init_done_seen", t_done >= 0, 1);
    chk("init_cmd_count", n, 4);
    chk("init_pre", {cc[0], 16'(tc[0] - rel)}, {PRE, 16'(INIT_WAIT)});
    chk("init_pre_a10", ac[0][10], 1'b1);
    chk("init_ref1", {cc[1], 16'(tc[1] - tc[0])}, {REF, 16'(TRP)});
    chk("init_ref2", {cc[2], 16'(tc[2] - tc[1])}, {REF, 16'(TRFC)});
    chk("init_mrs", {cc[3], 16'(tc[3] - tc[2])}, {MRS, 16'(TRFC)});
    chk("init_mrs_a", ac[3], 13'h0221);
    chk("init_done_delay", t_done - tc[3], 2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int rel, t_init, ta1, tr1, ta2, tr2, p, t_rd;
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.din = '0;
    mem[22'h12346] = 16'h1234;
    mem[22'h00A10] = 16'hC0DE;
    mem[22'h00A11] = 16'hFACE;
    mem[22'h0ABFF] = 16'hA5A5;
    mem[22'h0AA00] = 16'h5A5A;
    mem[22'h00100] = 16'h1111;
    mem[22'h00101] = 16'h2222;

    repeat (3) @(negedge clk);
    chk("rst_cmd", cmd, NOP);
    chk("rst_flags", {bus.ack, bus.rdy, init_done, oe}, 4'b0000);
    chk("rst_dqm_a_ba", {dqm, a, ba}, {2'b11, 13'h0000, 2'b00});
    chk("rst_dout", bus.dout, 32'h0);
    rst = 1'b0;
    rel = cyc;
    check_init(rel, t_init);

    // Write then read back
    do_req(0, 22'h12345, 16'hBEEF, 32'h0);
    do_req(1, 22'h12345, 16'h0000, 32'h1234BEEF);

    // rd and wr together: read wins, write follows after precharge
    push_req(1, 22'h00A10, 16'h7777, 32'hFACEC0DE);
    push_req(0, 22'h00A10, 16'h7777, 32'h0);
    bus.addr = 22'h00A10; bus.din = 16'h7777; bus.rd = 1'b1; bus.wr = 1'b1;
    wait_out(0, "both_ack1_seen", ta1);
    bus.rd = 1'b0;
    wait_out(1, "both_rdy1_seen", tr1);
    wait_out(0, "both_ack2_seen", ta2);
    bus.wr = 1'b0;
    chk("both_wr_gap", ta2 - tr1, TRP + 2);
    wait_out(1, "both_rdy2_seen", tr2);
    repeat (4) @(negedge clk);
    do_req(1, 22'h00A10, 16'h0000, 32'hFACE7777);

    // Column wrap inside the row
    do_req(1, 22'h0ABFF, 16'h0000, 32'h5A5AA5A5);

    // Refresh pending in the same cycle the read arrives
    p = t_init + TREFI;
    chk("rfsh_setup_in_time", cyc < p, 1);
    while (cyc < p) @(negedge clk);
    push_req(1, 22'h00100, 16'h0000, 32'h22221111);
    bus.addr = 22'h00100; bus.rd = 1'b1;
    wait_out(0, "rfsh_ack_seen", ta1);
    bus.rd = 1'b0;
    chk("rfsh_ref_cycle", last_ref - p, 1);
    chk("rfsh_ref_to_act", ta1 - last_ref, TRFC);
    chk("rfsh_count", n_ref, 1);
    wait_out(1, "rfsh_rdy_seen", tr1);
    repeat (4) @(negedge clk);

    // Reset between READ and first data beat
    push_req(1, 22'h00200, 16'h0000, 32'h0);
    bus.addr = 22'h00200; bus.rd = 1'b1;
    wait_out(0, "abort_ack_seen", ta1);
    bus.rd = 1'b0;
    t_rd = -1;
    for (int i = 0; i < 16 && t_rd < 0; i++) begin
      @(negedge clk);
      if (cmd == RDC) t_rd = cyc;
    end
    chk("abort_read_seen", t_rd >= 0, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_cmd", cmd, NOP);
    chk("abort_flags", {bus.ack, bus.rdy, init_done, oe}, 4'b0000);
    req_q.delete();
    have_cur = 0;
    after_wr = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    check_init(rel, t_init);
    do_req(1, 22'h12345, 16'h0000, 32'h1234BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
